// File: rtl/bcd_timer_pkg.sv
// Shared definitions for the four-digit BCD countdown timer: FSM encoding and BCD constants.
package bcd_timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_PAUSE   = 2'd2,
    ST_EXPIRED = 2'd3
  } state_e;

  localparam logic [3:0]  BCD_MAX  = 4'd9;
  localparam logic [15:0] BCD_ZERO = 16'h0000;

endpackage

// File: rtl/bcd_digit_dec.sv
// One BCD digit of the decrement borrow chain: 0 with a borrow wraps to 9 and borrows onward.
module bcd_digit_dec
  import bcd_timer_pkg::*;
(
  input  logic [3:0] digit,
  input  logic       borrow_in,
  output logic [3:0] digit_next,
  output logic       borrow_out
);

  always_comb begin
    digit_next = digit;
    borrow_out = 1'b0;
    if (borrow_in) begin
      if (digit == 4'd0) begin
        digit_next = BCD_MAX;
        borrow_out = 1'b1;
      end else begin
        digit_next = digit - 4'd1;
      end
    end
  end

endmodule

// File: rtl/bcd_countdown_timer.sv
// Four-digit BCD countdown timer with prescaled ticks, Done pulse and sticky Expired.
// Optional BCD_TIMER_AUTO_RELOAD_EN: reload the last accepted preset on expiry and keep running.
module bcd_countdown_timer
  import bcd_timer_pkg::*;
#(
  parameter int TICK_DIV = 50000,
  parameter int PRE_W    = 16
) (
  input  logic       Clock,
  input  logic       reset_n,
  input  logic       Load,
  input  logic       Start,
  input  logic       Stop,
  input  logic [3:0] Load_sec,
  input  logic [3:0] Load_tsec,
  input  logic [3:0] Load_hsec,
  input  logic [3:0] Load_msec,
  output logic [3:0] BCD_sec,
  output logic [3:0] BCD_tsec,
  output logic [3:0] BCD_hsec,
  output logic [3:0] BCD_msec,
  output logic       Running,
  output logic       Done,
  output logic       Expired,
  output logic       Load_err
);

  localparam logic [PRE_W-1:0] TICK_LAST = PRE_W'(TICK_DIV - 1);

  state_e            state_q, state_d;
  logic [PRE_W-1:0]  presc_q, presc_d;
  logic [15:0]       cnt_q, cnt_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              run_q, exp_q;
`ifdef BCD_TIMER_AUTO_RELOAD_EN
  logic [15:0]       shadow_q, shadow_d;
`endif

  logic [15:0] load_val;
  logic        load_ok;
  logic        tick;
  logic [15:0] cnt_dec;
  logic [4:0]  borrow;

  assign load_val = {Load_sec, Load_tsec, Load_hsec, Load_msec};
  assign load_ok  = (Load_sec <= BCD_MAX) && (Load_tsec <= BCD_MAX) &&
                    (Load_hsec <= BCD_MAX) && (Load_msec <= BCD_MAX);
  assign tick     = (state_q == ST_RUN) && (presc_q == TICK_LAST);

  // Borrow chain, msec first; borrow[4] set means the count was already 0000.
  assign borrow[0] = 1'b1;
  for (genvar i = 0; i < 4; i++) begin : g_dec
    bcd_digit_dec u_dec (
      .digit      (cnt_q[4*i +: 4]),
      .borrow_in  (borrow[i]),
      .digit_next (cnt_dec[4*i +: 4]),
      .borrow_out (borrow[i+1])
    );
  end

  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
`ifdef BCD_TIMER_AUTO_RELOAD_EN
    shadow_d = shadow_q;
`endif

    if (state_q == ST_RUN) begin
      presc_d = tick ? '0 : presc_q + 1'b1;
    end

    if (tick && !borrow[4]) begin
      cnt_d = cnt_dec;
      if (cnt_q == 16'h0001) begin
        done_d = 1'b1;
`ifdef BCD_TIMER_AUTO_RELOAD_EN
        if (shadow_q != BCD_ZERO) begin
          cnt_d = shadow_q;
        end else begin
          state_d = ST_EXPIRED;
        end
`else
        state_d = ST_EXPIRED;
`endif
      end
    end

    // Commands: Load beats Stop beats Start; a rejected Load still masks the others.
    if (Load) begin
      if (load_ok) begin
        cnt_d   = load_val;
        presc_d = '0;
        state_d = ST_IDLE;
        done_d  = 1'b0;
`ifdef BCD_TIMER_AUTO_RELOAD_EN
        shadow_d = load_val;
`endif
      end else begin
        err_d = 1'b1;
      end
    end else if (Stop) begin
      if (state_q == ST_RUN && state_d == ST_RUN) begin
        state_d = ST_PAUSE;
      end
    end else if (Start) begin
      case (state_q)
        ST_IDLE: begin
          if (cnt_q == BCD_ZERO) begin
            state_d = ST_EXPIRED;
            done_d  = 1'b1;
          end else begin
            state_d = ST_RUN;
          end
        end
        ST_PAUSE: state_d = ST_RUN;
        default:  ;
      endcase
    end
  end

  always_ff @(posedge Clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      presc_q  <= '0;
      cnt_q    <= BCD_ZERO;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      run_q    <= 1'b0;
      exp_q    <= 1'b0;
`ifdef BCD_TIMER_AUTO_RELOAD_EN
      shadow_q <= BCD_ZERO;
`endif
    end else begin
      state_q  <= state_d;
      presc_q  <= presc_d;
      cnt_q    <= cnt_d;
      done_q   <= done_d;
      err_q    <= err_d;
      run_q    <= (state_d == ST_RUN);
      exp_q    <= (state_d == ST_EXPIRED);
`ifdef BCD_TIMER_AUTO_RELOAD_EN
      shadow_q <= shadow_d;
`endif
    end
  end

  assign {BCD_sec, BCD_tsec, BCD_hsec, BCD_msec} = cnt_q;
  assign Running  = run_q;
  assign Done     = done_q;
  assign Expired  = exp_q;
  assign Load_err = err_q;

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Directed bench for bcd_countdown_timer at TICK_DIV=4; reload checks only when BCD_TIMER_AUTO_RELOAD_EN is defined.
module tb_bcd_countdown_timer;

  logic       Clock, reset_n, Load, Start, Stop;
  logic [3:0] Load_sec, Load_tsec, Load_hsec, Load_msec;
  logic [3:0] BCD_sec, BCD_tsec, BCD_hsec, BCD_msec;
  logic       Running, Done, Expired, Load_err;
  logic [15:0] bcd;

  int n_chk = 0;
  int n_err = 0;

  bcd_countdown_timer #(.TICK_DIV(4), .PRE_W(4)) dut (
    .Clock(Clock), .reset_n(reset_n), .Load(Load), .Start(Start), .Stop(Stop),
    .Load_sec(Load_sec), .Load_tsec(Load_tsec), .Load_hsec(Load_hsec), .Load_msec(Load_msec),
    .BCD_sec(BCD_sec), .BCD_tsec(BCD_tsec), .BCD_hsec(BCD_hsec), .BCD_msec(BCD_msec),
    .Running(Running), .Done(Done), .Expired(Expired), .Load_err(Load_err)
  );

  assign bcd = {BCD_sec, BCD_tsec, BCD_hsec, BCD_msec};

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge Clock);
      #1;
    end
  endtask

  task automatic do_load(input logic [3:0] s, input logic [3:0] t, input logic [3:0] h, input logic [3:0] m);
    Load_sec = s; Load_tsec = t; Load_hsec = h; Load_msec = m;
    Load = 1'b1;
    cyc();
    Load = 1'b0;
  endtask

  task automatic do_start();
    Start = 1'b1;
    cyc();
    Start = 1'b0;
  endtask

  task automatic do_stop();
    Stop = 1'b1;
    cyc();
    Stop = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; Load = 1'b0; Start = 1'b0; Stop = 1'b0;
    Load_sec = 4'd0; Load_tsec = 4'd0; Load_hsec = 4'd0; Load_msec = 4'd0;
    #2;
    check("rst_bcd", bcd, 16'h0000);
    check("rst_flags", {Running, Done, Expired, Load_err}, 4'b0000);
    @(negedge Clock);
    reset_n = 1'b1;
    cyc();

    // 0012 counts down to 0000 over 48 cycles
    do_load(4'd0, 4'd0, 4'd1, 4'd2);
    check("load12_bcd", bcd, 16'h0012);
    check("load12_run", Running, 1'b0);
    do_start();
    check("start_run", Running, 1'b1);
    cyc(3);
    check("pre_tick", bcd, 16'h0012);
    cyc();
    check("first_tick", bcd, 16'h0011);
    cyc(43);
    check("at47_bcd", bcd, 16'h0001);
    check("at47_done", Done, 1'b0);
    cyc();
    check("at48_bcd", bcd, 16'h0000);
    check("at48_flags", {Running, Done, Expired}, 3'b011);
    cyc();
    check("at49_done", Done, 1'b0);
    check("at49_exp", Expired, 1'b1);
    cyc(8);
    check("hold_zero", bcd, 16'h0000);
    check("hold_exp", Expired, 1'b1);

    // Three-level borrow 0100 -> 0099 -> 0098
    do_load(4'd0, 4'd1, 4'd0, 4'd0);
    check("load_clr_exp", Expired, 1'b0);
    do_start();
    cyc(4);
    check("borrow3", bcd, 16'h0099);
    cyc(4);
    check("borrow_next", bcd, 16'h0098);

    // Pause keeps the partial tick
    do_load(4'd0, 4'd0, 4'd5, 4'd0);
    do_start();
    cyc();
    do_stop();
    check("pause_run", Running, 1'b0);
    cyc(20);
    check("pause_bcd", bcd, 16'h0050);
    check("pause_flags", {Running, Done, Expired}, 3'b000);
    do_start();
    check("resume_run", Running, 1'b1);
    cyc();
    check("resume_p1", bcd, 16'h0050);
    cyc();
    check("resume_p2", bcd, 16'h0049);

    // Rejected load leaves count and state alone
    do_stop();
    Start = 1'b1;
    do_load(4'd0, 4'd0, 4'd0, 4'hA);
    Start = 1'b0;
    check("bad_err", Load_err, 1'b1);
    check("bad_bcd", bcd, 16'h0049);
    check("bad_run", Running, 1'b0);
    cyc();
    check("bad_err_pulse", Load_err, 1'b0);
    do_load(4'hF, 4'd1, 4'd2, 4'd3);
    check("bad_sec_err", Load_err, 1'b1);
    check("bad_sec_bcd", bcd, 16'h0049);
    do_start();
    check("bad_still_pause", Running, 1'b1);

    // Start on 0000 expires immediately
    do_load(4'd0, 4'd0, 4'd0, 4'd0);
    check("zero_exp0", Expired, 1'b0);
    do_start();
    check("zero_flags", {Running, Done, Expired}, 3'b011);
    cyc();
    check("zero_done_off", Done, 1'b0);
    cyc(8);
    check("zero_no_wrap", bcd, 16'h0000);

    // Asynchronous reset mid-count
    do_load(4'd0, 4'd0, 4'd0, 4'd8);
    do_start();
    cyc(12);
    check("mid_bcd", bcd, 16'h0005);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_bcd", bcd, 16'h0000);
    check("async_flags", {Running, Done, Expired, Load_err}, 4'b0000);
    cyc(3);
    check("in_rst_done", Done, 1'b0);
    @(negedge Clock);
    reset_n = 1'b1;
    cyc(8);
    check("post_rst", {bcd, Running, Done, Expired}, 19'd0);

`ifdef BCD_TIMER_AUTO_RELOAD_EN
    do_load(4'd0, 4'd0, 4'd0, 4'd2);
    do_start();
    cyc(4);
    check("ar_1", bcd, 16'h0001);
    cyc(4);
    check("ar_reload", bcd, 16'h0002);
    check("ar_flags", {Running, Done, Expired}, 3'b110);
    cyc();
    check("ar_done_off", Done, 1'b0);
    cyc(3);
    check("ar_1b", bcd, 16'h0001);
    cyc(4);
    check("ar_reload2", {bcd, Done, Expired}, {16'h0002, 2'b10});
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
